// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive / program-loader path.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StAccept
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle os_tick every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
// restart re-phases the divider so sampling lines up with a detected start edge.
module uart_baud_tick #(
  parameter int unsigned CLK_HZ     = 1_536_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic os_tick
);

  localparam int unsigned DivRaw = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned Div    = (DivRaw >= 1) ? DivRaw : 1;
  localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  assign os_tick = (cnt_q == CntMax);

  // Free-running divider, forced back to zero on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_loader.sv
// UART receiver and instruction-RAM program loader.
// Default build is 8N1. Defining UART_RX_PARITY_EN switches to 8E1 with a parity check.
// Good bytes are strobed out with load, counted up to MAX_BYTES, then prog_done is raised.
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1_536_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned MAX_BYTES  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        enable,
  output logic [7:0]  data_out,
  output logic        load,
  output logic [11:0] byte_count,
  output logic        prog_done,
  output logic        frame_err,
  output logic        parity_err
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [TickW-1:0] MidTick  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);
  localparam logic [11:0]      MaxCount = 12'(MAX_BYTES);

  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  logic                 os_tick;
  logic                 restart;
  rx_state_e            state_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q;
  logic                 parity_err_q;
`endif

  assign rx_s = rx_sync_q[1];

  // Re-phase the divider on the tick where a start edge moves the FSM out of idle.
  assign restart = (state_q == StIdle) && enable && os_tick && !rx_s;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .os_tick (os_tick)
  );

  // Two-flop synchroniser for the asynchronous serial line, reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= {IDLE_LEVEL, IDLE_LEVEL};
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
    end
  end

  // Receive FSM with registered data, count and strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out     <= '0;
      load         <= 1'b0;
      byte_count   <= '0;
      prog_done    <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle by default.
      load         <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (!enable) begin
        // Abort any frame and forget the image; data_out keeps the last byte.
        state_q    <= StIdle;
        byte_count <= '0;
        prog_done  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (os_tick && !rx_s) begin
              state_q    <= StStart;
              tick_cnt_q <= '0;
            end
          end
          StStart: begin
            if (os_tick) begin
              if (tick_cnt_q == MidTick) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                // A line that is high again at mid-bit was a glitch.
                state_q    <= rx_s ? StIdle : StData;
              end else begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
              end
            end
          end
          StData: begin
            if (os_tick) begin
              if (tick_cnt_q == LastTick) begin
                tick_cnt_q <= '0;
                shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                  state_q <= StParity;
`else
                  state_q <= StStop;
`endif
                end else begin
                  bit_cnt_q <= bit_cnt_q + BitW'(1);
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
              end
            end
          end
          StParity: begin
`ifdef UART_RX_PARITY_EN
            if (os_tick) begin
              if (tick_cnt_q == LastTick) begin
                tick_cnt_q   <= '0;
                parity_bad_q <= (rx_s != ^shift_q);
                state_q      <= StStop;
              end else begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
              end
            end
`else
            state_q <= StIdle;
`endif
          end
          StStop: begin
            if (os_tick) begin
              if (tick_cnt_q == LastTick) begin
                tick_cnt_q <= '0;
                state_q    <= StIdle;
`ifdef UART_RX_PARITY_EN
                if (parity_bad_q) begin
                  // Parity failure wins over a bad stop bit.
                  parity_err_q <= 1'b1;
                end else
`endif
                if (!rx_s) begin
                  frame_err <= 1'b1;
                end else begin
                  // Load is issued here so it is visible during the accept cycle.
                  state_q <= StAccept;
                  if (byte_count < MaxCount) begin
                    data_out   <= shift_q;
                    load       <= 1'b1;
                    byte_count <= byte_count + 12'd1;
                    prog_done  <= ((byte_count + 12'd1) == MaxCount);
                  end
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
              end
            end
          end
          StAccept: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader at 1.536 MHz / 9600 baud (160 clocks per bit).
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the 8E1 build.
module tb_uart_rx_loader;

  localparam int unsigned BitClk = 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  data_out;
  logic        load;
  logic [11:0] byte_count;
  logic        prog_done;
  logic        frame_err;
  logic        parity_err;

  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int coinc_cnt = 0;
  int off_cnt = 0;
  logic [7:0] load_log[$];
`ifdef UART_RX_PARITY_EN
  logic tx_par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_loader #(
    .CLK_HZ     (1_536_000),
    .BAUD       (9600),
    .OVERSAMPLE (16),
    .MAX_BYTES  (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .enable     (enable),
    .data_out   (data_out),
    .load       (load),
    .byte_count (byte_count),
    .prog_done  (prog_done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      load_log.push_back(data_out);
      if (frame_err || parity_err) coinc_cnt++;
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (frame_err && parity_err) coinc_cnt++;
    if (!enable && (load || frame_err || parity_err)) off_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BitClk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ tx_par_flip);
`endif
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  initial begin
    int loads0;
    int ferr0;
    int perr0;
    logic [7:0] part;

    // Reset state
    #2;
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst load", 32'(load), 32'h0);
    check("rst byte_count", 32'(byte_count), 32'h0);
    check("rst prog_done", 32'(prog_done), 32'h0);
    check("rst frame_err", 32'(frame_err), 32'h0);
    check("rst parity_err", 32'(parity_err), 32'h0);
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    enable = 1'b1;
    wait_clk(BitClk);

    // 1: single byte
    send_byte(8'hA5, 1'b1);
    wait_clk(20);
    check("t1 load count", 32'(load_cnt), 32'd1);
    check("t1 data_out", 32'(data_out), 32'hA5);
    check("t1 byte_count", 32'(byte_count), 32'd1);
    check("t1 frame_err count", 32'(ferr_cnt), 32'd0);
    check("t1 parity_err count", 32'(perr_cnt), 32'd0);

    // Clear the count before loading a full image
    enable = 1'b0;
    wait_clk(3);
    check("dis byte_count", 32'(byte_count), 32'd0);
    enable = 1'b1;
    wait_clk(BitClk);

    // 2: full image back-to-back, then one extra byte
    load_log.delete();
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), 1'b1);
      check($sformatf("t2 byte_count after %0d", i), 32'(byte_count), 32'(i));
      check($sformatf("t2 prog_done after %0d", i), 32'(prog_done), (i == 6) ? 32'd1 : 32'd0);
    end
    check("t2 load log size", 32'(load_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < load_log.size(); i++) begin
      check($sformatf("t2 load order %0d", i), 32'(load_log[i]), 32'(i + 1));
    end
    loads0 = load_cnt;
    send_byte(8'h07, 1'b1);
    wait_clk(20);
    check("t2 extra no load", 32'(load_cnt), 32'(loads0));
    check("t2 extra byte_count", 32'(byte_count), 32'd6);
    check("t2 extra data_out held", 32'(data_out), 32'h06);
    check("t2 extra prog_done", 32'(prog_done), 32'd1);

    enable = 1'b0;
    wait_clk(3);
    check("dis prog_done cleared", 32'(prog_done), 32'd0);
    check("dis byte_count cleared", 32'(byte_count), 32'd0);
    enable = 1'b1;
    wait_clk(BitClk);

    // 3: short low glitch is rejected
    loads0 = load_cnt;
    ferr0 = ferr_cnt;
    rx = 1'b0;
    wait_clk(64);
    rx = 1'b1;
    wait_clk(2 * BitClk);
    check("t3 glitch no load", 32'(load_cnt), 32'(loads0));
    check("t3 glitch no frame_err", 32'(ferr_cnt), 32'(ferr0));

    // 4: framing error, then the same byte cleanly
    send_byte(8'h3C, 1'b0);
    wait_clk(BitClk);
    check("t4 frame_err pulse", 32'(ferr_cnt), 32'(ferr0 + 1));
    check("t4 ferr no load", 32'(load_cnt), 32'(loads0));
    check("t4 ferr byte_count", 32'(byte_count), 32'd0);
    send_byte(8'h3C, 1'b1);
    wait_clk(20);
    check("t4 clean load", 32'(load_cnt), 32'(loads0 + 1));
    check("t4 clean data_out", 32'(data_out), 32'h3C);
    check("t4 clean byte_count", 32'(byte_count), 32'd1);

    // 5: asynchronous reset during data bit 4
    part = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    rx = part[4];
    wait_clk(80);
    #3;
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("t5 rst data_out", 32'(data_out), 32'h0);
    check("t5 rst byte_count", 32'(byte_count), 32'd0);
    check("t5 rst load", 32'(load), 32'd0);
    check("t5 rst prog_done", 32'(prog_done), 32'd0);
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2 * BitClk);
    loads0 = load_cnt;
    send_byte(8'h5A, 1'b1);
    wait_clk(20);
    check("t5 load after rst", 32'(load_cnt), 32'(loads0 + 1));
    check("t5 data_out", 32'(data_out), 32'h5A);
    check("t5 byte_count", 32'(byte_count), 32'd1);

    // Enable dropped mid-frame
    loads0 = load_cnt;
    ferr0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_clk(40);
    enable = 1'b0;
    wait_clk(2);
    check("abort byte_count", 32'(byte_count), 32'd0);
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    rx = 1'b1;
    wait_clk(2 * BitClk);
    enable = 1'b1;
    wait_clk(BitClk);
    check("abort no load", 32'(load_cnt), 32'(loads0));
    check("abort no frame_err", 32'(ferr_cnt), 32'(ferr0));
    check("abort data_out held", 32'(data_out), 32'h5A);
    check("abort no strobe while disabled", 32'(off_cnt), 32'd0);

    // 0x00 is a legal byte
    send_byte(8'h00, 1'b1);
    wait_clk(20);
    check("zero byte load", 32'(load_cnt), 32'(loads0 + 1));
    check("zero byte data_out", 32'(data_out), 32'h00);
    check("zero byte byte_count", 32'(byte_count), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 6: parity checking on 0x07 (even parity bit must be 1)
    loads0 = load_cnt;
    perr0 = perr_cnt;
    tx_par_flip = 1'b1;
    send_byte(8'h07, 1'b1);
    tx_par_flip = 1'b0;
    wait_clk(20);
    check("t6 parity_err pulse", 32'(perr_cnt), 32'(perr0 + 1));
    check("t6 bad parity no load", 32'(load_cnt), 32'(loads0));
    send_byte(8'h07, 1'b1);
    wait_clk(20);
    check("t6 good parity load", 32'(load_cnt), 32'(loads0 + 1));
    check("t6 data_out", 32'(data_out), 32'h07);
    check("t6 byte_count", 32'(byte_count), 32'd2);
`else
    perr0 = perr_cnt;
    check("no parity_err in 8N1", 32'(perr0), 32'd0);
`endif

    check("strobes mutually exclusive", 32'(coinc_cnt), 32'd0);
    check("no strobe while disabled", 32'(off_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
